// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: PC + control + data, with valid, flush, stall-hold and NOP-bubble insertion.
// Latency 1 cycle, all outputs registered; stall holds contents in place and flush overrides stall.
module pipe_stage_reg #(
  parameter int          CTRL_W   = 20,
  parameter int          DATA_W   = 101,
  parameter logic [31:0] PC_RESET = 32'h3000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  input  logic [31:0]       pc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [31:0]       pc_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              held,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out     <= PC_RESET;
      ctrl_out   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      held       <= 1'b0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      // Killed slot keeps the incoming PC so exception/branch logic can still see it.
      pc_out    <= pc_in;
      ctrl_out  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      held      <= 1'b0;
    end else if (stall) begin
      held <= 1'b1;
      if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end else if (bubble) begin
      // All-zero control word decodes to a NOP downstream.
      pc_out    <= pc_in;
      ctrl_out  <= '0;
      data_out  <= data_in;
      valid_out <= 1'b0;
      held      <= 1'b0;
      if (bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_ONE;
    end else begin
      pc_out    <= pc_in;
      ctrl_out  <= ctrl_in;
      data_out  <= data_in;
      valid_out <= valid_in;
      held      <= 1'b0;
    end
  end

endmodule
